// File: rtl/acc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : acc_bus_ctrl
//  Brief    : Bus-side initiator for the A/B accumulator register pair.
//             Turns a valid/ready command stream into strobed register
//             writes, enabled reads and an A<->B swap. One response is
//             returned per command.
//  Revision : 1.0  initial release
// ============================================================================
module acc_bus_ctrl #(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [2:0]    CMD_OP,
    input  logic [DW-1:0] CMD_DATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [DW-1:0] RSP_DATA,
    output logic          RSP_ERR,
    output logic [DW-1:0] DIN,
    output logic          IAn,
    output logic          IBn,
    output logic          EAn,
    output logic          EBn,
    input  logic [DW-1:0] DOUT_IN
);

    // Command opcodes
    localparam logic [2:0] C_OP_WR_A = 3'b000;
    localparam logic [2:0] C_OP_WR_B = 3'b001;
    localparam logic [2:0] C_OP_RD_A = 3'b010;
    localparam logic [2:0] C_OP_RD_B = 3'b011;
    localparam logic [2:0] C_OP_SWAP = 3'b100;

    // WR doubles as the final swap step (load B with the saved A value);
    // RD doubles as the one-cycle delay before an illegal-opcode response.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_SW1  = 3'd3,
        ST_SW2  = 3'd4,
        ST_SW3  = 3'd5,
        ST_SW4  = 3'd6,
        ST_RSP  = 3'd7
    } state_t;

    state_t        state_q,     state_d;
    logic          err_q,       err_d;
    logic [DW-1:0] din_q,       din_d;
    logic [DW-1:0] tmp_a_q,     tmp_a_d;
    logic          ia_n_q,      ia_n_d;
    logic          ib_n_q,      ib_n_d;
    logic          ea_n_q,      ea_n_d;
    logic          eb_n_q,      eb_n_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q,  rsp_data_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          cmd_ready_q, cmd_ready_d;

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        din_d       = din_q;
        tmp_a_d     = tmp_a_q;
        ia_n_d      = ia_n_q;
        ib_n_d      = ib_n_q;
        ea_n_d      = ea_n_q;
        eb_n_d      = eb_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    case (CMD_OP)
                        C_OP_WR_A: begin din_d = CMD_DATA; ia_n_d = 1'b0; state_d = ST_WR; end
                        C_OP_WR_B: begin din_d = CMD_DATA; ib_n_d = 1'b0; state_d = ST_WR; end
                        C_OP_RD_A: begin ea_n_d = 1'b0; state_d = ST_RD; end
                        C_OP_RD_B: begin eb_n_d = 1'b0; state_d = ST_RD; end
                        C_OP_SWAP: begin ea_n_d = 1'b0; state_d = ST_SW1; end
                        default:   begin err_d  = 1'b1; state_d = ST_RD; end
                    endcase
                end
            end
            ST_WR: begin
                // Target register captures DIN on this edge
                ia_n_d      = 1'b1;
                ib_n_d      = 1'b1;
                rsp_data_d  = din_q;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RD: begin
                ea_n_d      = 1'b1;
                eb_n_d      = 1'b1;
                rsp_data_d  = err_q ? '0 : DOUT_IN;
                rsp_err_d   = err_q;
                err_d       = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_SW1: begin
                // Save old A, then leave the read bus idle for one cycle
                tmp_a_d = DOUT_IN;
                ea_n_d  = 1'b1;
                state_d = ST_SW2;
            end
            ST_SW2: begin
                eb_n_d  = 1'b0;
                state_d = ST_SW3;
            end
            ST_SW3: begin
                din_d   = DOUT_IN;
                eb_n_d  = 1'b1;
                ia_n_d  = 1'b0;
                state_d = ST_SW4;
            end
            ST_SW4: begin
                ia_n_d  = 1'b1;
                din_d   = tmp_a_q;
                ib_n_d  = 1'b0;
                state_d = ST_WR;
            end
            ST_RSP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready is registered, so derive it from where the FSM is heading
        cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
    end

    // State and output registers; reset forces every strobe/enable inactive
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            din_q       <= '0;
            tmp_a_q     <= '0;
            ia_n_q      <= 1'b1;
            ib_n_q      <= 1'b1;
            ea_n_q      <= 1'b1;
            eb_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            din_q       <= din_d;
            tmp_a_q     <= tmp_a_d;
            ia_n_q      <= ia_n_d;
            ib_n_q      <= ib_n_d;
            ea_n_q      <= ea_n_d;
            eb_n_q      <= eb_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign DIN       = din_q;
    assign IAn       = ia_n_q;
    assign IBn       = ib_n_q;
    assign EAn       = ea_n_q;
    assign EBn       = eb_n_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_bus_ctrl
//  Brief    : Self-checking bench for acc_bus_ctrl with a behavioural model
//             of the A/B register pair and an expected-contents model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_bus_ctrl;

    localparam int DW = 8;

    logic          CLK       = 1'b0;
    logic          RSTn      = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic [2:0]    CMD_OP    = 3'd0;
    logic [DW-1:0] CMD_DATA  = '0;
    logic          RSP_READY = 1'b0;
    logic          CMD_READY;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_DATA;
    logic          RSP_ERR;
    logic [DW-1:0] DIN;
    logic          IAn, IBn, EAn, EBn;
    logic [DW-1:0] DOUT_IN;

    // Accumulator register pair attached to the bus
    logic [DW-1:0] reg_a = '0;
    logic [DW-1:0] reg_b = '0;

    // Expected register contents, updated per command
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;

    int tests = 0;
    int fails = 0;

    // Bus monitor state
    int            n_ia = 0, n_ib = 0, n_ea = 0, n_eb = 0, viol = 0;
    logic          prev_ea_low = 1'b0;
    logic [DW-1:0] din_ia = '0, din_ib = '0;

    acc_bus_ctrl #(.DW(DW)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_DATA  (CMD_DATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .DIN       (DIN),
        .IAn       (IAn),
        .IBn       (IBn),
        .EAn       (EAn),
        .EBn       (EBn),
        .DOUT_IN   (DOUT_IN)
    );

    always #5 CLK = ~CLK;

    // Read bus: selected register, or a marker value when idle
    assign DOUT_IN = !EAn ? reg_a : (!EBn ? reg_b : 8'hEE);

    // Registers load at the edge ending a cycle with their strobe low
    always @(posedge CLK) begin
        if (!IAn) reg_a <= DIN;
        if (!IBn) reg_b <= DIN;
    end

    // Count strobe/enable cycles and bus-rule violations
    always @(negedge CLK) begin
        if (!IAn) begin n_ia <= n_ia + 1; din_ia <= DIN; end
        if (!IBn) begin n_ib <= n_ib + 1; din_ib <= DIN; end
        if (!EAn) n_ea <= n_ea + 1;
        if (!EBn) n_eb <= n_eb + 1;
        if ((!EAn && !EBn) || (!IAn && !IBn) ||
            ((!IAn || !IBn) && (!EAn || !EBn)) ||
            (prev_ea_low && !EBn))
            viol <= viol + 1;
        prev_ea_low <= !EAn;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, optionally stall the response, and check everything
    task automatic do_cmd(input logic [2:0] op, input logic [DW-1:0] data, input int hold);
        int            n, lat, exp_lat;
        int            s_ia, s_ib, s_ea, s_eb, s_v;
        int            e_ia, e_ib, e_ea, e_eb;
        logic [DW-1:0] exp_data, held;
        logic          exp_err;
        s_ia = n_ia; s_ib = n_ib; s_ea = n_ea; s_eb = n_eb; s_v = viol;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
        chk("ready_wait", n < 20, 1);

        exp_err = 1'b0; exp_lat = 2; exp_data = '0;
        e_ia = 0; e_ib = 0; e_ea = 0; e_eb = 0;
        case (op)
            3'd0: begin exp_data = data;  e_ia = 1; end
            3'd1: begin exp_data = data;  e_ib = 1; end
            3'd2: begin exp_data = exp_a; e_ea = 1; end
            3'd3: begin exp_data = exp_b; e_eb = 1; end
            3'd4: begin exp_data = exp_a; exp_lat = 6; e_ia = 1; e_ib = 1; e_ea = 1; e_eb = 1; end
            default: exp_err = 1'b1;
        endcase

        CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = data;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0; CMD_OP = 3'($urandom); CMD_DATA = 8'($urandom);
        lat = 1;
        while (RSP_VALID !== 1'b1 && lat < 20) begin @(posedge CLK); #1; lat++; end
        chk("latency",    lat,       exp_lat);
        chk("rsp_data",   RSP_DATA,  exp_data);
        chk("rsp_err",    RSP_ERR,   exp_err);
        chk("ready_busy", CMD_READY, 0);
        held = RSP_DATA;

        if (hold > 0) begin
            // A competing WRITE_B must not be accepted while the response waits
            CMD_VALID = 1'b1; CMD_OP = 3'd1; CMD_DATA = ~data;
            for (int i = 0; i < hold; i++) begin
                @(posedge CLK); #1;
                chk("hold_valid", RSP_VALID, 1);
                chk("hold_data",  RSP_DATA,  held);
                chk("hold_ready", CMD_READY, 0);
            end
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0; CMD_VALID = 1'b0;
        chk("rsp_clear", RSP_VALID, 0);
        chk("ready_ret", CMD_READY, 1);

        chk("cnt_ia", n_ia - s_ia, e_ia);
        chk("cnt_ib", n_ib - s_ib, e_ib);
        chk("cnt_ea", n_ea - s_ea, e_ea);
        chk("cnt_eb", n_eb - s_eb, e_eb);
        chk("bus_rules", viol - s_v, 0);
        if (op == 3'd0) chk("din_a", din_ia, data);
        if (op == 3'd1) chk("din_b", din_ib, data);
        if (op == 3'd4) begin
            chk("swap_din_a", din_ia, exp_b);
            chk("swap_din_b", din_ib, exp_a);
        end

        case (op)
            3'd0: exp_a = data;
            3'd1: exp_b = data;
            3'd4: begin exp_a = exp_b; exp_b = exp_data; end
            default: ;
        endcase
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_ia",    IAn, 1);
        chk("rst_ib",    IBn, 1);
        chk("rst_ea",    EAn, 1);
        chk("rst_eb",    EBn, 1);
        chk("rst_din",   DIN, 0);
        chk("rst_valid", RSP_VALID, 0);
        chk("rst_data",  RSP_DATA, 0);
        chk("rst_err",   RSP_ERR, 0);
        chk("rst_ready", CMD_READY, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        chk("ready_after_rst", CMD_READY, 1);

        // Directed sequence
        do_cmd(3'd0, 8'h5A, 0);
        do_cmd(3'd1, 8'hC3, 0);
        do_cmd(3'd3, 8'h00, 0);
        do_cmd(3'd0, 8'h11, 0);
        do_cmd(3'd1, 8'h22, 0);
        do_cmd(3'd4, 8'h00, 0);
        chk("model_a_swapped", exp_a, reg_a);
        do_cmd(3'd2, 8'h00, 0);
        do_cmd(3'd3, 8'h00, 0);
        do_cmd(3'd6, 8'hFF, 0);
        do_cmd(3'd2, 8'h00, 5);

        // Reset during SW3
        CMD_VALID = 1'b1; CMD_OP = 3'd4;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("sw3_eb_low", EBn, 0);
        RSTn = 1'b0;
        #1;
        chk("arst_ia",    IAn, 1);
        chk("arst_ib",    IBn, 1);
        chk("arst_ea",    EAn, 1);
        chk("arst_eb",    EBn, 1);
        chk("arst_valid", RSP_VALID, 0);
        chk("arst_ready", CMD_READY, 0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        chk("arst_ready_ret", CMD_READY, 1);
        do_cmd(3'd2, 8'h00, 0);
        do_cmd(3'd3, 8'h00, 0);

        // Randomized commands
        for (int k = 0; k < 40; k++)
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)));
        do_cmd(3'd2, 8'h00, 0);
        do_cmd(3'd3, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_bus_ctrl.md
Name: acc_bus_ctrl

Overview:
- Bus-side initiator for the dual accumulator register pair (A/B). It generates the active-low load strobes (IAn/IBn), the active-low output enables (EAn/EBn) and the write data bus, and it samples the shared read bus.
- Converts a valid/ready command stream from the control unit into correctly sequenced register writes, reads and an A<->B swap.
- Guarantees that EAn and EBn are never low together, so the shared read bus is never contended.

Parameters:
- DW, 8, data bus width (the accumulator registers are 8-bit; no other value is supported).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RSTn  input  1  asynchronous active-low reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  controller can accept a command.
- CMD_OP  input  3  000 WRITE_A, 001 WRITE_B, 010 READ_A, 011 READ_B, 100 SWAP, 101..111 illegal.
- CMD_DATA  input  DW  write data (WRITE_A/WRITE_B only).
- RSP_VALID  output  1  response available.
- RSP_READY  input  1  response consumer ready.
- RSP_DATA  output  DW  result (see Behaviour).
- RSP_ERR  output  1  high with RSP_VALID for an illegal opcode.
- DIN  output  DW  write bus to the accumulator register data inputs.
- IAn  output  1  load strobe, register A, active-low.
- IBn  output  1  load strobe, register B, active-low.
- EAn  output  1  output enable, register A onto the read bus, active-low.
- EBn  output  1  output enable, register B onto the read bus, active-low.
- DOUT_IN  input  DW  shared read bus from the accumulator registers.

Behaviour:
- All outputs are registered. Reset values: IAn=IBn=EAn=EBn=1, DIN=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, state IDLE, CMD_READY=0 while RSTn is low.
- CMD_READY=1 only in IDLE with RSP_VALID=0. A command is accepted on a rising edge where CMD_VALID&CMD_READY.
- The target registers load on the CLK edge that ends a cycle in which their strobe is low. Every strobe is low for exactly one cycle per use.
- States: IDLE, WR, RD, SW1, SW2, SW3, SW4, RSP.
- WRITE_A/B:
  - Accept edge: DIN<=CMD_DATA, IAn (or IBn)<=0, state->WR.
  - Next edge: the register captures; strobe<=1, RSP_DATA<=DIN, RSP_VALID<=1, state->RSP.
  - Accept-to-RSP_VALID latency is 2 edges.
- READ_A/B:
  - Accept edge: EAn (or EBn)<=0, state->RD.
  - Next edge: RSP_DATA<=DOUT_IN, enable<=1, RSP_VALID<=1, state->RSP.
- SWAP (5 edges):
  - Accept: EAn<=0, ->SW1.
  - SW1 edge: tmpA<=DOUT_IN, EAn<=1, ->SW2 (bus-idle cycle).
  - SW2 edge: EBn<=0, ->SW3.
  - SW3 edge: DIN<=DOUT_IN, EBn<=1, IAn<=0, ->SW4.
  - SW4 edge: IAn<=1, DIN<=tmpA, IBn<=0, ->SW5 (encoded as WR with select B).
  - Final edge: IBn<=1, RSP_DATA<=tmpA (old A), RSP_VALID<=1.
- Illegal opcode: the command is accepted, no strobe or enable is asserted; the next edge sets RSP_VALID=1, RSP_ERR=1, RSP_DATA=0.
- RSP: RSP_VALID holds with stable RSP_DATA/RSP_ERR until RSP_VALID&RSP_READY at an edge, which clears it. Return to IDLE on that edge; CMD_READY goes high the following cycle.
- Invariants, checked every cycle:
  - never (EAn==0 && EBn==0);
  - never (IAn==0 && IBn==0);
  - a load strobe is never low in the same cycle as any output enable;
  - an EAn->EBn transition always has at least one cycle with both high.
- Reset mid-operation: all strobes and enables return to 1 immediately (asynchronous); any in-flight command is dropped with no response. A partially completed SWAP may leave A updated and B not; this is accepted.
- CMD_VALID while busy is ignored (no accept); CMD_* need not be held stable after acceptance.

Test Plan:
- Reset then WRITE_A 0x5A -> IAn low exactly 1 cycle with DIN=0x5A; RSP_VALID 2 edges after accept, RSP_DATA=0x5A, RSP_ERR=0.
- WRITE_B 0xC3, then READ_B with the bench model returning QB on DOUT_IN -> EBn low 1 cycle, RSP_DATA=0xC3; EAn stays 1 throughout.
- A=0x11, B=0x22, SWAP -> RSP_DATA=0x11; subsequent READ_A=0x22 and READ_B=0x11; an assertion monitor confirms no EAn/EBn overlap and the bus-idle cycle is present.
- CMD_OP=110 -> RSP_VALID with RSP_ERR=1 and RSP_DATA=0x00; all four strobes/enables stay 1.
- Hold RSP_READY=0 for 5 cycles after READ_A -> RSP_VALID and RSP_DATA stable, CMD_READY=0, and a back-to-back command is not accepted until the response handshake completes.
- Assert RSTn low during SW3 -> IAn, IBn, EAn and EBn all 1 asynchronously, RSP_VALID=0; after release CMD_READY=1 within 1 cycle.
